// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types: word/line widths and the L1/L2 arbiter
// state and grant-source encodings.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] pmem_L1_bus;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

endpackage

// File: rtl/arb_cmd_reg.sv
// Load-enabled holding register for the granted L2 command (address, write
// line, read/write). Loaded once per transaction, held until the next grant.
module arb_cmd_reg
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  lc3b_word   address_d,
  input  pmem_L1_bus wdata_d,
  input  logic       read_d,
  input  logic       write_d,
  output lc3b_word   address,
  output pmem_L1_bus wdata,
  output logic       read,
  output logic       write
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address <= '0;
      wdata   <= '0;
      read    <= 1'b0;
      write   <= 1'b0;
    end else if (load) begin
      address <= address_d;
      wdata   <= wdata_d;
      read    <= read_d;
      write   <= write_d;
    end
  end

endmodule

// File: rtl/l1_pmem_arbiter.sv
// Arbitrates the single L2 line port between the L1 icache and dcache miss paths.
// Define L1_ARB_ROUND_ROBIN_EN for alternating grants under contention (default: dcache priority).
module l1_pmem_arbiter
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       icache_pmem_read,
  input  lc3b_word   icache_pmem_address,
  output logic       icache_pmem_resp,
  output pmem_L1_bus icache_pmem_rdata,
  input  logic       dcache_pmem_read,
  input  logic       dcache_pmem_write,
  input  lc3b_word   dcache_pmem_address,
  input  pmem_L1_bus dcache_pmem_wdata,
  output logic       dcache_pmem_resp,
  output pmem_L1_bus dcache_pmem_rdata,
  output logic       l2_read,
  output logic       l2_write,
  output lc3b_word   l2_address,
  output pmem_L1_bus l2_wdata,
  input  logic       l2_resp,
  input  pmem_L1_bus l2_rdata,
  output arb_state_t dbg_state,
  output arb_src_t   dbg_last_grant
);

  // Handshake: a cache holds its request until it sees a one-cycle resp; the
  // arbiter holds l2_read/l2_write stable from cmd_reg until l2_resp is seen.
  arb_state_t state_q, state_d;
  arb_src_t   last_grant_q, last_grant_d;
  logic       i_req, d_req, pick_d, load;
  lc3b_word   address_d;
  pmem_L1_bus wdata_d;
  logic       read_d, write_d, cmd_read, cmd_write;

  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;

  always_comb begin
    pick_d = d_req;
`ifdef L1_ARB_ROUND_ROBIN_EN
    if (i_req && d_req) pick_d = (last_grant_q == SRC_I);
`endif
  end

  // Read+write together from the dcache is illegal and resolves to a write.
  assign address_d = pick_d ? dcache_pmem_address : icache_pmem_address;
  assign wdata_d   = pick_d ? dcache_pmem_wdata : '0;
  assign read_d    = pick_d ? ~dcache_pmem_write : 1'b1;
  assign write_d   = pick_d & dcache_pmem_write;

  arb_cmd_reg u_cmd_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .address_d (address_d),
    .wdata_d   (wdata_d),
    .read_d    (read_d),
    .write_d   (write_d),
    .address   (l2_address),
    .wdata     (l2_wdata),
    .read      (cmd_read),
    .write     (cmd_write)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    load             = 1'b0;
    l2_read          = 1'b0;
    l2_write         = 1'b0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          load    = 1'b1;
          state_d = pick_d ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        l2_read  = cmd_read;
        l2_write = cmd_write;
        if (l2_resp) begin
          icache_pmem_resp = 1'b1;
          last_grant_d     = SRC_I;
          state_d          = RECOVER;
        end
      end
      SERVE_D: begin
        l2_read  = cmd_read;
        l2_write = cmd_write;
        if (l2_resp) begin
          dcache_pmem_resp = 1'b1;
          last_grant_d     = SRC_D;
          state_d          = RECOVER;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Both caches see the L2 line; only the granted one gets a resp.
  assign icache_pmem_rdata = l2_rdata;
  assign dcache_pmem_rdata = l2_rdata;
  assign dbg_state         = state_q;
  assign dbg_last_grant    = last_grant_q;

endmodule

// File: tb/tb_l1_pmem_arbiter.sv
// Directed, table-driven bench for l1_pmem_arbiter with hand-written sequences
// for request drop, mid-transaction reset and contention ordering.
module tb_l1_pmem_arbiter;
  import lc3b_types::*;

  logic       clk, reset;
  logic       icache_pmem_read, icache_pmem_resp;
  lc3b_word   icache_pmem_address;
  pmem_L1_bus icache_pmem_rdata;
  logic       dcache_pmem_read, dcache_pmem_write, dcache_pmem_resp;
  lc3b_word   dcache_pmem_address;
  pmem_L1_bus dcache_pmem_wdata, dcache_pmem_rdata;
  logic       l2_read, l2_write, l2_resp;
  lc3b_word   l2_address;
  pmem_L1_bus l2_wdata, l2_rdata;
  arb_state_t dbg_state;
  arb_src_t   dbg_last_grant;

  int checks = 0;
  int errors = 0;

  l1_pmem_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .icache_pmem_read    (icache_pmem_read),
    .icache_pmem_address (icache_pmem_address),
    .icache_pmem_resp    (icache_pmem_resp),
    .icache_pmem_rdata   (icache_pmem_rdata),
    .dcache_pmem_read    (dcache_pmem_read),
    .dcache_pmem_write   (dcache_pmem_write),
    .dcache_pmem_address (dcache_pmem_address),
    .dcache_pmem_wdata   (dcache_pmem_wdata),
    .dcache_pmem_resp    (dcache_pmem_resp),
    .dcache_pmem_rdata   (dcache_pmem_rdata),
    .l2_read             (l2_read),
    .l2_write            (l2_write),
    .l2_address          (l2_address),
    .l2_wdata            (l2_wdata),
    .l2_resp             (l2_resp),
    .l2_rdata            (l2_rdata),
    .dbg_state           (dbg_state),
    .dbg_last_grant      (dbg_last_grant)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         i_rd;
    logic [15:0]  i_addr;
    logic         d_rd;
    logic         d_wr;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    int           lat;
    logic [127:0] rdata;
    logic         exp_d;
    logic         exp_rd;
    logic         exp_wr;
    logic [15:0]  exp_addr;
    logic [127:0] exp_wdata;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drop_all();
    icache_pmem_read  = 1'b0;
    dcache_pmem_read  = 1'b0;
    dcache_pmem_write = 1'b0;
  endtask

  // Waits (bounded) for an L2 strobe, checks the command, answers after lat
  // cycles and checks the resp routing and the RECOVER cycle. Returns at the
  // negedge inside RECOVER.
  task automatic do_txn(input string tag, input logic exp_d, input logic exp_rd,
                        input logic exp_wr, input logic [15:0] exp_addr,
                        input logic [127:0] exp_wdata, input int exp_wait,
                        input int lat, input logic [127:0] rd, input logic drop);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(l2_read || l2_write) && n < 8);
    chk({tag, "_wait"}, n, exp_wait);
    chk({tag, "_state"}, dbg_state, exp_d ? SERVE_D : SERVE_I);
    chk({tag, "_rd"}, l2_read, exp_rd);
    chk({tag, "_wr"}, l2_write, exp_wr);
    chk({tag, "_addr"}, l2_address, exp_addr);
    if (exp_wr) chk({tag, "_wdata"}, l2_wdata, exp_wdata);
    if (drop) drop_all();
    repeat (lat) @(negedge clk);
    chk({tag, "_held"}, {l2_read, l2_write}, {exp_rd, exp_wr});
    l2_resp  = 1'b1;
    l2_rdata = rd;
    #1;
    chk({tag, "_iresp"}, icache_pmem_resp, !exp_d);
    chk({tag, "_dresp"}, dcache_pmem_resp, exp_d);
    chk({tag, "_rdata"}, exp_d ? dcache_pmem_rdata : icache_pmem_rdata, rd);
    @(negedge clk);
    l2_resp = 1'b0;
    #1;
    chk({tag, "_recover"}, dbg_state, RECOVER);
    chk({tag, "_rec_strobe"}, {l2_read, l2_write}, 2'b00);
    chk({tag, "_rec_resp"}, {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
    chk({tag, "_last"}, dbg_last_grant, exp_d ? SRC_D : SRC_I);
  endtask

  initial begin
    logic exp_d;
    reset = 1'b1;
    drop_all();
    icache_pmem_address = '0;
    dcache_pmem_address = '0;
    dcache_pmem_wdata   = '0;
    l2_resp  = 1'b0;
    l2_rdata = '0;

    vecs[0] = '{1'b1, 16'h1230, 1'b0, 1'b0, 16'h0000, '0, 3, {16{8'hAA}},
                1'b0, 1'b1, 1'b0, 16'h1230, '0};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h4560, '0, 1, {8{16'h0123}},
                1'b1, 1'b1, 1'b0, 16'h4560, '0};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, {16{8'h55}}, 2, {16{8'h0F}},
                1'b1, 1'b0, 1'b1, 16'h2000, {16{8'h55}}};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h3000, {8{16'hDEAD}}, 0, {16{8'hC3}},
                1'b1, 1'b0, 1'b1, 16'h3000, {8{16'hDEAD}}};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_strobes", {l2_read, l2_write}, 2'b00);
    chk("rst_resps", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
    chk("rst_addr", l2_address, 16'h0);
    chk("rst_wdata", l2_wdata, 128'h0);
    chk("rst_last", dbg_last_grant, SRC_I);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_noreq", dbg_state, IDLE);

    // Single-requester vectors
    for (int i = 0; i < 4; i++) begin
      icache_pmem_read    = vecs[i].i_rd;
      icache_pmem_address = vecs[i].i_addr;
      dcache_pmem_read    = vecs[i].d_rd;
      dcache_pmem_write   = vecs[i].d_wr;
      dcache_pmem_address = vecs[i].d_addr;
      dcache_pmem_wdata   = vecs[i].d_wdata;
      do_txn($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_rd, vecs[i].exp_wr,
             vecs[i].exp_addr, vecs[i].exp_wdata, 1, vecs[i].lat, vecs[i].rdata, 1'b0);
      drop_all();
      @(negedge clk);
    end

    // Dcache drops its request mid-transaction
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 16'h4800;
    do_txn("drop", 1'b1, 1'b1, 1'b0, 16'h4800, '0, 1, 2, {4{32'h600DF00D}}, 1'b1);
    @(negedge clk);
    chk("drop_idle", dbg_state, IDLE);
    chk("drop_noresp", dcache_pmem_resp, 1'b0);
    chk("drop_nostrobe", l2_read, 1'b0);

    // Asynchronous reset two cycles into SERVE_I
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h7000;
    @(negedge clk);
    chk("arst_serve", l2_read, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    reset   = 1'b1;
    l2_resp = 1'b1;
    #1;
    chk("arst_strobe", l2_read, 1'b0);
    chk("arst_noresp", icache_pmem_resp, 1'b0);
    chk("arst_state", dbg_state, IDLE);
    @(negedge clk);
    reset   = 1'b0;
    l2_resp = 1'b0;
    do_txn("arst_retry", 1'b0, 1'b1, 1'b0, 16'h7000, '0, 1, 1, {16{8'h3C}}, 1'b0);
    drop_all();
    @(negedge clk);

    // Contention: dcache first, then the held icache request
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 16'h1000;
    dcache_pmem_write   = 1'b1;
    dcache_pmem_address = 16'h2000;
    dcache_pmem_wdata   = {16{8'h55}};
    do_txn("both_d", 1'b1, 1'b0, 1'b1, 16'h2000, {16{8'h55}}, 1, 1, {16{8'h11}}, 1'b0);
    dcache_pmem_write = 1'b0;
    do_txn("both_i", 1'b0, 1'b1, 1'b0, 16'h1000, '0, 2, 2, {16{8'h22}}, 1'b0);

    // Four rounds of sustained contention
    dcache_pmem_write = 1'b1;
    for (int r = 0; r < 4; r++) begin
`ifdef L1_ARB_ROUND_ROBIN_EN
      exp_d = (r % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      do_txn($sformatf("round%0d", r), exp_d, !exp_d, exp_d,
             exp_d ? 16'h2000 : 16'h1000, {16{8'h55}}, 2, 1, {8{r[15:0]}}, 1'b0);
    end
    drop_all();
    @(negedge clk);
    chk("end_idle", dbg_state, IDLE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
